// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with operand-ready scoreboard.
//
// After reset a clear sequence walks every entry and writes zero, one entry
// per clock, while busy is high. Once it finishes the file accepts one write
// per cycle and serves NRD combinational reads. Each read bypasses a write to
// the same address in the same cycle. A pending bit per entry tracks an
// outstanding multi-cycle producer.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset, restarts the clear sequence
//   ra    - NRD read addresses, port i at [i*AW +: AW]
//   rd    - NRD read data words, port i at [i*WIDTH +: WIDTH]
//   rrdy  - per read port: operand ready (no pending producer)
//   we/wa/wd - write enable, address, data
//   pset/pa  - mark entry pa pending
//   busy  - registered, high while the clear sequence runs
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic [NRD-1:0]       rrdy,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [WIDTH-1:0]     wd,
    input  logic                 pset,
    input  logic [AW-1:0]        pa,
    output logic                 busy
);

    localparam int DEPTH = 2 ** AW;
    localparam bit ZR    = (ZERO_REG != 0);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    // DEPTH is a power of two, so the last pointer value is all ones.
    localparam logic [AW-1:0] LAST = '1;

    logic [0:0]       state;
    logic [AW-1:0]    ptr;
    logic [DEPTH-1:0] pending;
    logic [WIDTH-1:0] rf [DEPTH];

    // Entry 0 is hardwired when ZERO_REG is set; writes and pending-sets to
    // it are dropped.
    logic wr_ok;
    logic ps_ok;
    assign wr_ok = we   && (state == RUN) && !(ZR && (wa == '0));
    assign ps_ok = pset && (state == RUN) && !(ZR && (pa == '0));

    // Storage port shared between the clear sequence and normal writes.
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa;
        mem_wd = wd;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we = 1'b1;
                mem_wa = ptr;
                mem_wd = '0;
            end else begin
                mem_we = wr_ok;
            end
        end
    end

    // Control: FSM, clear pointer, busy flag, pending scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            ptr     <= '0;
            busy    <= 1'b1;
            pending <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST) begin
                state <= RUN;
                busy  <= 1'b0;
            end
        end else begin
            // Clear first, then set, so a same-address set wins.
            if (wr_ok) pending[wa] <= 1'b0;
            if (ps_ok) pending[pa] <= 1'b1;
        end
    end

    // Data storage carries no reset; the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) rf[mem_wa] <= mem_wd;
    end

    // Combinational read ports with same-cycle write bypass.
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] a;
        logic          zhit;
        logic          byp;
        assign a    = ra[g*AW +: AW];
        assign zhit = ZR && (a == '0);
        assign byp  = we && (wa == a);

        assign rd[g*WIDTH +: WIDTH] = busy ? '0 :
                                      zhit ? '0 :
                                      byp  ? wd : rf[a];
        assign rrdy[g] = !busy && (zhit || !pending[a] || byp);
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rrdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        pset;
    logic [4:0]  pa;
    logic        busy;

    int tests;
    int fails;

    // Scoreboard: expectations queued when stimulus is applied, checked when
    // outputs are sampled.
    string       tagq[$];
    logic [63:0] rdq[$];
    logic [1:0]  rdyq[$];
    logic        bq[$];

    regfile_mp dut (
        .clk  (clk),
        .rst  (rst),
        .ra   (ra),
        .rd   (rd),
        .rrdy (rrdy),
        .we   (we),
        .wa   (wa),
        .wd   (wd),
        .pset (pset),
        .pa   (pa),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ra(input logic [4:0] a1, input logic [4:0] a0);
        ra = {a1, a0};
    endtask

    task automatic expect_out(input string tag, input logic [31:0] rd1,
                              input logic [31:0] rd0, input logic [1:0] erdy,
                              input logic eb);
        tagq.push_back(tag);
        rdq.push_back({rd1, rd0});
        rdyq.push_back(erdy);
        bq.push_back(eb);
    endtask

    task automatic check_out();
        string       t;
        logic [63:0] erd;
        logic [1:0]  erdy;
        logic        eb;
        while (tagq.size() > 0) begin
            t    = tagq.pop_front();
            erd  = rdq.pop_front();
            erdy = rdyq.pop_front();
            eb   = bq.pop_front();
            tests++;
            assert (rd === erd && rrdy === erdy && busy === eb) else begin
                fails++;
                $error("FAIL %s: rd=%h rrdy=%b busy=%b, expected rd=%h rrdy=%b busy=%b",
                       t, rd, rrdy, busy, erd, erdy, eb);
            end
        end
    endtask

    // Sample mid-cycle, then take one rising edge; inputs change 1 ns after it.
    task automatic cycle();
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    // n clear cycles with stray writes/pending-sets that must be ignored.
    task automatic clear_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            we = 1'b1; wa = 5'd3; wd = 32'hBAD0_0000 + i;
            pset = 1'b1; pa = 5'd7;
            set_ra(5'd7, 5'd3);
            expect_out("clear_busy", 32'h0, 32'h0, 2'b00, 1'b1);
            cycle();
        end
        we = 1'b0; pset = 1'b0;
    endtask

    task automatic run_clear();
        clear_cycles(32);
        set_ra(5'd7, 5'd3);
        expect_out("clear_done", 32'h0, 32'h0, 2'b11, 1'b0);
        cycle();
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; pset = 1'b0; pa = '0; ra = '0;

        @(posedge clk);
        #1;
        expect_out("reset_state", 32'h0, 32'h0, 2'b00, 1'b1);
        cycle();                          // rst still high: ptr held at 0
        rst = 1'b0;
        run_clear();

        // every entry reads zero and ready
        for (int a = 0; a < 32; a++) begin
            set_ra(5'(31 - a), 5'(a));
            expect_out("post_clear_read", 32'h0, 32'h0, 2'b11, 1'b0);
            cycle();
        end

        // same-cycle bypass, then stored value
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; set_ra(5'd6, 5'd5);
        expect_out("bypass_w5", 32'h0, 32'hDEAD_BEEF, 2'b11, 1'b0);
        cycle();
        we = 1'b0;
        expect_out("stored_w5", 32'h0, 32'hDEAD_BEEF, 2'b11, 1'b0);
        cycle();

        // write to entry 0 ignored
        we = 1'b1; wa = 5'd0; wd = 32'h1234; set_ra(5'd0, 5'd0);
        expect_out("zero_write_same", 32'h0, 32'h0, 2'b11, 1'b0);
        cycle();
        we = 1'b0;
        expect_out("zero_write_after", 32'h0, 32'h0, 2'b11, 1'b0);
        cycle();

        // pending on 7, cleared by write
        pset = 1'b1; pa = 5'd7; set_ra(5'd7, 5'd5);
        expect_out("pset7_same", 32'h0, 32'hDEAD_BEEF, 2'b11, 1'b0);
        cycle();
        pset = 1'b0;
        expect_out("pend7", 32'h0, 32'hDEAD_BEEF, 2'b01, 1'b0);
        cycle();
        expect_out("pend7_hold", 32'h0, 32'hDEAD_BEEF, 2'b01, 1'b0);
        cycle();
        we = 1'b1; wa = 5'd7; wd = 32'h55;
        expect_out("wr7_bypass", 32'h55, 32'hDEAD_BEEF, 2'b11, 1'b0);
        cycle();
        we = 1'b0;
        expect_out("wr7_cleared", 32'h55, 32'hDEAD_BEEF, 2'b11, 1'b0);
        cycle();

        // set and write same address: set wins
        pset = 1'b1; pa = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'hA; set_ra(5'd9, 5'd9);
        expect_out("set_wr9_same", 32'hA, 32'hA, 2'b11, 1'b0);
        cycle();
        pset = 1'b0; we = 1'b0;
        expect_out("set_wins9", 32'hA, 32'hA, 2'b00, 1'b0);
        cycle();
        we = 1'b1; wa = 5'd9; wd = 32'hB;
        expect_out("wr9_byp", 32'hB, 32'hB, 2'b11, 1'b0);
        cycle();
        we = 1'b0;
        expect_out("wr9_after", 32'hB, 32'hB, 2'b11, 1'b0);
        cycle();

        // pending-set to entry 0 ignored
        pset = 1'b1; pa = 5'd0; set_ra(5'd0, 5'd0);
        cycle();
        pset = 1'b0;
        expect_out("pset0_ignored", 32'h0, 32'h0, 2'b11, 1'b0);
        cycle();

        // mid-RUN reset with data and a pending bit present
        we = 1'b1; wa = 5'd3; wd = 32'h77; pset = 1'b1; pa = 5'd7;
        cycle();
        we = 1'b0; pset = 1'b0; set_ra(5'd7, 5'd3);
        expect_out("pre_rst", 32'h55, 32'h77, 2'b01, 1'b0);
        cycle();
        rst = 1'b1;
        expect_out("rst_edge_run", 32'h55, 32'h77, 2'b01, 1'b0);
        cycle();
        rst = 1'b0;
        clear_cycles(10);                 // ptr now 10
        rst = 1'b1; set_ra(5'd7, 5'd3);
        expect_out("rst_mid_clear", 32'h0, 32'h0, 2'b00, 1'b1);
        cycle();
        rst = 1'b0;
        run_clear();
        set_ra(5'd9, 5'd5);
        expect_out("cleared_5_9", 32'h0, 32'h0, 2'b11, 1'b0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter AW, default 5, address width; DEPTH = 2**AW entries.
REQ-003 Parameter NRD, default 2, number of combinational read ports.
REQ-004 Parameter ZERO_REG, default 1, when 1 entry 0 reads as zero and ignores writes and pending-sets.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ra  in  NRD*AW  read addresses, port i at bits [i*AW +: AW].
REQ-008 rd  out  NRD*WIDTH  read data, port i at bits [i*WIDTH +: WIDTH].
REQ-009 rrdy  out  NRD  port i operand ready (no pending producer).
REQ-010 we  in  1  write enable.
REQ-011 wa  in  AW  write address.
REQ-012 wd  in  WIDTH  write data.
REQ-013 pset  in  1  mark entry pa as pending (outstanding multi-cycle producer).
REQ-014 pa  in  AW  pending-set address.
REQ-015 busy  out  1  registered; high while the clear sequence runs.

Function
REQ-016 FSM states CLEAR and RUN; a rising edge with rst=1 forces CLEAR, clear pointer ptr=0, all pending bits 0, busy=1.
REQ-017 In CLEAR with rst=0, each edge writes 0 to rf[ptr] and increments ptr; the edge on which ptr==DEPTH-1 writes the last entry, enters RUN and drives busy=0.
REQ-018 The clear therefore takes exactly DEPTH edges after rst deasserts; holding rst high keeps ptr at 0.
REQ-019 While busy=1: we and pset are ignored, every rd port drives 0, every rrdy bit drives 0.
REQ-020 In RUN, a rising edge with we=1 writes wd to rf[wa], except wa==0 when ZERO_REG=1.
REQ-021 Read port i (RUN): rd_i = 0 if ZERO_REG=1 and ra_i==0; else wd if we=1 and wa==ra_i (same-cycle bypass); else rf[ra_i].
REQ-022 Multiple read ports addressing the same entry return identical data.
REQ-023 Pending bit update per edge in RUN: pset=1 sets pending[pa]; we=1 clears pending[wa]; pset and we to the same address in one cycle leave the bit set (set wins).
REQ-024 pset to entry 0 with ZERO_REG=1 is ignored.
REQ-025 rrdy_i = 1 if (ZERO_REG=1 and ra_i==0), or pending[ra_i]==0, or (we=1 and wa==ra_i); else 0; combinational.
REQ-026 rd and rrdy are combinational from ra, we, wa, wd and state; no read latency.
REQ-027 No other entry or pending bit changes on any edge.

Reset
REQ-028 Reset is synchronous active-high on clk; no asynchronous path.
REQ-029 After the reset edge: busy=1, all pending=0, state CLEAR; rd=0 and rrdy=0 on all ports until busy falls.
REQ-030 After busy falls, every entry reads 0 and every rrdy=1.
REQ-031 rst asserted mid-clear or mid-operation restarts the clear from ptr=0 and discards pending bits.

Verification
REQ-032 Reset then rst=0, defaults: busy high for exactly 32 edges, then low; reading all 32 addresses returns 0 with rrdy=1.
REQ-033 RUN, we=1 wa=5 wd=0xDEADBEEF, ra0=5 same cycle -> rd0=0xDEADBEEF before the edge; next cycle with we=0 rd0=0xDEADBEEF.
REQ-034 we=1 wa=0 wd=0x1234, ra0=0 ra1=0 -> rd0=rd1=0 in that cycle and afterwards; rrdy=2'b11.
REQ-035 pset=1 pa=7 one edge; ra1=7 -> rrdy[1]=0; later we=1 wa=7 wd=0x55 -> rrdy[1]=1 and rd1=0x55 in that cycle, pending cleared after the edge.
REQ-036 pset=1 pa=9 and we=1 wa=9 wd=0xA on the same edge -> rf[9]=0xA, rrdy for ra=9 is 0 next cycle.
REQ-037 Write rf[3]=0x77, pulse rst at ptr=10 during a second clear and mid-RUN -> busy high for a full 32 edges each time, rf[3] reads 0 afterwards; we pulses during busy have no effect.
